// File: rtl/gf180mcu_osu_sc_12t_rstseq_pkg.sv
// Shared types and default constants for the staged reset-release sequencer.
// The state encoding is fixed so it can be probed from the netlist.
package gf180mcu_osu_sc_12t_rstseq_pkg;

   typedef enum logic [2:0] {
      RESET   = 3'd0,
      STRETCH = 3'd1,
      RELEASE = 3'd2,
      RUN     = 3'd3,
      SWRST   = 3'd4
   } state_t;

   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_STRETCH_CYCLES = 16;
   localparam int DEF_STAGE_GAP      = 4;
   localparam int DEF_NUM_DOMAINS    = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12t_rstsync.sv
// Async-assert / sync-release reset synchronizer. The first flop's D comes
// from a tie-high cell, so sync_n goes high SYNC_STAGES edges after RN rises.
module gf180mcu_osu_sc_12t_rstsync
   import gf180mcu_osu_sc_12t_rstseq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic CLK,
   input  logic RN,
   input  logic TIE,
   output logic sync_n
);

   logic [SYNC_STAGES-1:0] sync;

   // NOTE: the clear sits in the sensitivity list so RN takes effect with no
   // clock running; only the release is retimed through the flop chain.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], TIE};
      end
   end

   assign sync_n = sync[SYNC_STAGES-1];

endmodule

// File: rtl/gf180mcu_osu_sc_12t_rstseq.sv
// Reset release sequencer: synchronize, stretch, then release the domain
// resets one by one; a software request replays the stretch and release.
module gf180mcu_osu_sc_12t_rstseq
   import gf180mcu_osu_sc_12t_rstseq_pkg::*;
#(
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
   parameter int STAGE_GAP      = DEF_STAGE_GAP,
   parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS
) (
   input  logic                   CLK,
   input  logic                   RN,
   input  logic                   TIE,
   input  logic                   SRST_REQ,
   output logic                   SRST_ACK,
   output logic [NUM_DOMAINS-1:0] RSTN_OUT,
   output logic                   READY
);

   localparam int CW = $clog2(max_int(STRETCH_CYCLES, STAGE_GAP) + 1);
   localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DOMAINS - 1);
   localparam logic [NUM_DOMAINS-1:0] FIRST_DOMAIN = NUM_DOMAINS'(1);

   logic          sync_n;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;

   gf180mcu_osu_sc_12t_rstsync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .CLK    (CLK),
      .RN     (RN),
      .TIE    (TIE),
      .sync_n (sync_n)
   );

   // NOTE: every state and output register uses <= so all of them sample the
   // same pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state    <= RESET;
         cnt      <= '0;
         idx      <= '0;
         RSTN_OUT <= '0;
         READY    <= 1'b0;
         SRST_ACK <= 1'b0;
      end else begin
         SRST_ACK <= 1'b0;
         case (state)
            RESET: begin
               if (sync_n) begin
                  state <= STRETCH;
                  cnt   <= '0;
               end
            end

            STRETCH: begin
               if (cnt == STRETCH_LAST) begin
                  state    <= RELEASE;
                  RSTN_OUT <= FIRST_DOMAIN;
                  idx      <= '0;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RELEASE: begin
               // Domains come up in index order, so shifting in a one
               // releases exactly the next domain.
               if (idx == IDX_LAST) begin
                  state <= RUN;
                  READY <= 1'b1;
                  cnt   <= '0;
               end else if (cnt == GAP_LAST) begin
                  idx      <= idx + 1'b1;
                  RSTN_OUT <= (RSTN_OUT << 1) | FIRST_DOMAIN;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RUN: begin
               if (SRST_REQ) begin
                  state    <= SWRST;
                  RSTN_OUT <= '0;
                  READY    <= 1'b0;
                  cnt      <= '0;
               end
            end

            SWRST: begin
               if (cnt == STRETCH_LAST) begin
                  state    <= RELEASE;
                  RSTN_OUT <= FIRST_DOMAIN;
                  idx      <= '0;
                  cnt      <= '0;
                  SRST_ACK <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state    <= RESET;
               cnt      <= '0;
               idx      <= '0;
               RSTN_OUT <= '0;
               READY    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_rstseq.sv
// Scoreboard bench: a default sequencer and a minimal-parameter corner
// sequencer share one random stimulus stream and are checked every cycle.
module tb_gf180mcu_osu_sc_12t_rstseq;

   localparam int SYNC = 2;
   localparam longint INF = 64'd1 << 40;

   logic clk = 1'b0;
   logic rn  = 1'b1;
   logic tie = 1'b1;
   logic srst_req = 1'b0;

   logic       ack0, ready0, ack1, ready1;
   logic [2:0] rstn0;
   logic [0:0] rstn1;

   gf180mcu_osu_sc_12t_rstseq dut_dflt (
      .CLK      (clk),
      .RN       (rn),
      .TIE      (tie),
      .SRST_REQ (srst_req),
      .SRST_ACK (ack0),
      .RSTN_OUT (rstn0),
      .READY    (ready0)
   );

   gf180mcu_osu_sc_12t_rstseq #(
      .SYNC_STAGES    (SYNC),
      .STRETCH_CYCLES (1),
      .STAGE_GAP      (1),
      .NUM_DOMAINS    (1)
   ) dut_corner (
      .CLK      (clk),
      .RN       (rn),
      .TIE      (tie),
      .SRST_REQ (srst_req),
      .SRST_ACK (ack1),
      .RSTN_OUT (rstn1),
      .READY    (ready1)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: each domain k is released at base + gap*k, READY one
   // edge after the last domain, and a software reset moves base forward.
   int     st[2], gap[2], nd[2];
   longint base[2], ack_at[2];
   longint n = 0;
   logic [4:0] q0[$];
   logic [4:0] q1[$];

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s edge %0d: {rstn,ready,ack} got %b expected %b", name, n, act, exp);
      end
   endtask

   task automatic model_edge(input int d, input logic rn_i, input logic req_i);
      longint run_at;
      logic [4:0] e;
      if (!rn_i) begin
         base[d]   = INF;
         ack_at[d] = -1;
      end else begin
         run_at = base[d] + gap[d] * (nd[d] - 1) + 1;
         if (n > run_at && req_i) begin
            base[d]   = n + st[d];
            ack_at[d] = n + st[d];
         end
      end
      run_at = base[d] + gap[d] * (nd[d] - 1) + 1;
      e = '0;
      for (int k = 0; k < nd[d]; k++) e[2+k] = (n >= base[d] + gap[d] * k);
      e[1] = (n >= run_at);
      e[0] = (n == ack_at[d]);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic step(input logic req_i);
      srst_req = req_i;
      @(posedge clk);
      n++;
      model_edge(0, rn, req_i);
      model_edge(1, rn, req_i);
      #1;
   endtask

   task automatic release_rn();
      rn = 1'b1;
      for (int d = 0; d < 2; d++) begin
         base[d]   = tie ? n + SYNC + 1 + st[d] : INF;
         ack_at[d] = -1;
      end
   endtask

   // Drops RN late in the cycle, after the monitor has sampled, and checks
   // that the outputs clear with no clock edge.
   task automatic async_drop();
      #6;
      rn = 1'b0;
      #1;
      check("async_dflt", {rstn0, ready0, ack0}, 5'b00000);
      check("async_corner", {2'b00, rstn1, ready1, ack1}, 5'b00000);
      for (int d = 0; d < 2; d++) begin
         base[d]   = INF;
         ack_at[d] = -1;
      end
   endtask

   always @(negedge clk) begin
      logic [4:0] e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         check("dflt", {rstn0, ready0, ack0}, e);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check("corner", {2'b00, rstn1, ready1, ack1}, e);
      end
   end

   initial begin
      st  = '{16, 1};
      gap = '{4, 1};
      nd  = '{3, 1};
      base   = '{INF, INF};
      ack_at = '{-1, -1};

      #1 rn = 1'b0;
      #1;
      check("reset_dflt", {rstn0, ready0, ack0}, 5'b00000);
      check("reset_corner", {2'b00, rstn1, ready1, ack1}, 5'b00000);

      // Power-on, then one single-cycle software reset from RUN.
      repeat (3) step(1'b0);
      release_rn();
      repeat (35) step(1'b0);
      step(1'b1);
      repeat (30) step(1'b0);

      // Requests during STRETCH (edge 6) and RELEASE (edge 21) are ignored.
      async_drop();
      repeat (2) step(1'b0);
      release_rn();
      for (int e = 1; e <= 40; e++) step((e == 6) || (e == 21));

      // RN dropped between edges while the default block shows 3'b011.
      async_drop();
      repeat (2) step(1'b0);
      release_rn();
      repeat (24) step(1'b0);
      async_drop();
      repeat (2) step(1'b0);
      release_rn();
      repeat (40) step(1'b0);

      // Random request traffic, then a long held request.
      for (int i = 0; i < 400; i++) step($urandom_range(0, 7) == 0);
      repeat (20) step(1'b1);
      repeat (30) step(1'b0);

      // Tie cell stuck low: the block must never leave RESET.
      async_drop();
      tie = 1'b0;
      repeat (2) step(1'b0);
      release_rn();
      for (int i = 0; i < 100; i++) step($urandom_range(0, 3) == 0);

      async_drop();
      tie = 1'b1;
      repeat (2) step(1'b0);
      release_rn();
      repeat (30) step(1'b0);

      for (int i = 0; i < 4 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
      #1;
      n_checks++;
      if ((q0.size() + q1.size()) != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", q0.size() + q1.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gf180mcu_osu_sc_12t_rstseq.md
Name: gf180mcu_osu_sc_12T_rstseq

Overview:
- Reset release sequencer that directly consumes a tie-high cell output.
- The TIE input is the constant-1 D source of an internal reset synchronizer chain.
- After the synchronized release, the block stretches reset, then deasserts NUM_DOMAINS active-low domain resets in a staggered order.
- Supports a software-requested reset with a req/ack handshake. Sits between the tie/pad-reset cells and the core's per-domain reset nets.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count (>=2).
- STRETCH_CYCLES, 16, cycles reset is held after synchronized release, and the duration of a software reset (>=1).
- STAGE_GAP, 4, cycles between successive domain releases (>=1).
- NUM_DOMAINS, 3, number of staged domain resets (>=1).

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- TIE  input  1  constant-1 from tie-high cell; D of first sync flop.
- SRST_REQ  input  1  software reset request, level; sampled only in RUN.
- SRST_ACK  output  1  one-cycle pulse when software reset hold completes.
- RSTN_OUT  output  NUM_DOMAINS  staged active-low domain resets; bit 0 released first.
- READY  output  1  high when all domains are released (state RUN).

Behaviour:
- Clock and reset: one clock, CLK. RN is asynchronous and active-low; assertion takes effect immediately, without waiting for a clock edge.
- Reset values (while RN=0): sync flops 0, state RESET, counter 0, domain index 0, RSTN_OUT all 0, READY 0, SRST_ACK 0. All outputs are registered.
- Synchronizer:
  - sync[0] <= TIE; sync[i] <= sync[i-1]; sync_n = sync[SYNC_STAGES-1].
  - If TIE=0, sync_n stays 0 and the block remains in RESET indefinitely.
- RESET: when sync_n=1, go to STRETCH at the next edge with cnt=0.
- STRETCH:
  - cnt increments each cycle.
  - On the edge where cnt==STRETCH_CYCLES-1: go to RELEASE, set RSTN_OUT[0]=1, idx=0, cnt=0.
- RELEASE:
  - cnt increments each cycle.
  - When cnt==STAGE_GAP-1 and idx<NUM_DOMAINS-1: idx++, RSTN_OUT[idx]=1, cnt=0.
  - When idx==NUM_DOMAINS-1: go to RUN and set READY=1 one cycle after the last bit is released.
- Domain release timing: RSTN_OUT[k] rises STAGE_GAP*k cycles after RSTN_OUT[0]. Bits never drop except by RN or a software reset.
- RUN: if SRST_REQ=1 at an edge, go to SWRST at that edge: RSTN_OUT all 0, READY 0, cnt=0.
- SWRST:
  - Hold for STRETCH_CYCLES cycles.
  - On the edge where cnt==STRETCH_CYCLES-1: go to RELEASE (RSTN_OUT[0]=1, idx=0) and assert SRST_ACK=1 for exactly that cycle.
- SRST_REQ rules:
  - Ignored in RESET, STRETCH, RELEASE and SWRST; no ack is issued there.
  - The requester drops SRST_REQ after SRST_ACK. If SRST_REQ is still high when RUN is re-entered, a new software reset starts on the first RUN edge.
- Counter width: localparam CW = $clog2(max(STRETCH_CYCLES, STAGE_GAP)+1). The counter never wraps; it is cleared on every state change.
- NUM_DOMAINS=1: RELEASE lasts exactly 1 cycle before RUN.
- RN asserted mid-sequence (any state): all outputs drop to reset values asynchronously. The full sequence restarts from the synchronizer after RN deasserts.
- RN deassertion is always resynchronized; RN never releases RSTN_OUT directly.
- Timing with defaults: RN rises before edge 1, counting edges after RN rises.
  - sync_n=1 after edge 2; STRETCH entered at edge 3.
  - RSTN_OUT[0] rises at edge 19, RSTN_OUT[1] at edge 23, RSTN_OUT[2] at edge 27.
  - READY rises at edge 28.

Decomposition:
- Package gf180mcu_osu_sc_12T_rstseq_pkg holds:
  - state typedef: RESET=3'd0, STRETCH=3'd1, RELEASE=3'd2, RUN=3'd3, SWRST=3'd4.
  - default parameter constants.
- Sub-module gf180mcu_osu_sc_12T_rstsync: the SYNC_STAGES-flop async-clear synchronizer (inputs CLK, RN, TIE; output sync_n). Instantiated once.

Test Plan:
- Power-on: RN=0 for 3 cycles, then 1, TIE=1, defaults -> RSTN_OUT=3'b000 through edge 18; 3'b001 at edge 19, 3'b011 at 23, 3'b111 at 27; READY=1 at edge 28.
- TIE stuck 0: RN released, run 100 cycles -> RSTN_OUT=3'b000, READY=0 throughout, state RESET.
- Software reset: in RUN, SRST_REQ=1 for 1 cycle at edge E -> RSTN_OUT=0 and READY=0 from E; SRST_ACK=1 only at edge E+16 with RSTN_OUT=3'b001; READY=1 at E+25.
- SRST_REQ outside RUN: pulse SRST_REQ during STRETCH and again during RELEASE -> no SWRST, no SRST_ACK; release timing identical to the power-on case.
- Async reset mid-RELEASE: drop RN between clock edges after RSTN_OUT=3'b011 -> RSTN_OUT=0 and READY=0 immediately, without a clock edge; after RN rises, the full sequence repeats with the same edge offsets.
- Parameter corner: NUM_DOMAINS=1, STRETCH_CYCLES=1, STAGE_GAP=1 -> RSTN_OUT[0] rises at edge 4, READY at edge 5; a software reset held high yields SRST_ACK every 3 cycles.
